// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode and state encodings, flag bundle
// and the flag-derivation helper used by both the single-cycle and MUL paths.
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_NOT_A = 3'd2,
    OP_AND   = 3'd3,
    OP_OR    = 3'd4,
    OP_XOR   = 3'd5,
    OP_MUL   = 3'd6,
    OP_RSVD  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic n;
  } alu_flags_t;

  // z and n are taken from the low result word only, so callers pass those bits in.
  function automatic alu_flags_t calc_flags(input logic c, input logic v,
                                            input logic res_zero, input logic res_msb);
    alu_flags_t f;
    f.c = c;
    f.v = v;
    f.z = res_zero;
    f.n = res_msb;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_WIDTH steps.
// product presents the accumulator value after the current step so done and product line up.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] product
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic [2*DATA_WIDTH-1:0] mcand_q;
  logic [2*DATA_WIDTH-1:0] acc_q;
  logic [2*DATA_WIDTH-1:0] partial;
  logic [2*DATA_WIDTH-1:0] acc_next;
  logic [DATA_WIDTH-1:0]   mplier_q;
  logic [CW-1:0]           cnt_q;
  logic                    busy_q;

  assign partial  = mplier_q[0] ? mcand_q : '0;
  assign acc_next = acc_q + partial;
  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == CW'(DATA_WIDTH - 1));
  assign product  = acc_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= {{DATA_WIDTH{1'b0}}, a};
      acc_q    <= '0;
      mplier_q <= b;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/pipelined_alu.sv
// Handshaked ALU: single-cycle logic/arith ops plus an iterative MUL, with a
// registered result held until the consumer takes it.
//
//   state | meaning
//   IDLE  | no result pending, ready for a new op
//   BUSY  | multiplier stepping, no input accepted
//   HOLD  | result valid, frozen until out_ready
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = OP_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic                  flag_c,
  output logic                  flag_v,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic                  err
);

  localparam int MSB = DATA_WIDTH - 1;

  alu_state_e state_q, state_d;
  alu_op_e    op_e;
  logic       accept, is_mul, load_alu, load_mul;

  logic [DATA_WIDTH:0]   sum_ext, diff_ext;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_c, alu_v, alu_err;
  alu_flags_t            alu_flags, mul_flags, flags_q;

  logic                    mul_busy, mul_done;
  logic [2*DATA_WIDTH-1:0] mul_product;
  logic [DATA_WIDTH-1:0]   mul_lo, mul_hi;

  logic [DATA_WIDTH-1:0] result_q, result_hi_q;
  logic                  err_q;

  assign op_e     = alu_op_e'(op);
  assign is_mul   = (op_e == OP_MUL);
  assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;
  assign load_alu = accept && !is_mul;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} + {1'b0, ~b} + {{DATA_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op_e)
      OP_ADD: begin
        alu_res = sum_ext[MSB:0];
        alu_c   = sum_ext[DATA_WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
      end
      OP_SUB: begin
        // carry-out of a + ~b + 1 is the inverse of the unsigned borrow
        alu_res = diff_ext[MSB:0];
        alu_c   = ~diff_ext[DATA_WIDTH];
        alu_v   = (a[MSB] != b[MSB]) && (diff_ext[MSB] != a[MSB]);
      end
      OP_NOT_A: alu_res = ~a;
      OP_AND:   alu_res = a & b;
      OP_OR:    alu_res = a | b;
      OP_XOR:   alu_res = a ^ b;
      OP_MUL:   alu_res = '0;
      default:  alu_err = 1'b1;
    endcase
  end

  assign alu_flags = calc_flags(alu_c, alu_v, alu_res == '0, alu_res[MSB]);

  alu_mul_iter #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk     (clk),
    .resetn  (resetn),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign mul_lo    = mul_product[MSB:0];
  assign mul_hi    = mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
  assign mul_flags = calc_flags(mul_hi != '0, 1'b0, mul_lo == '0, mul_lo[MSB]);

  always_comb begin
    state_d  = state_q;
    load_mul = 1'b0;
    case (state_q)
      IDLE: if (in_valid) state_d = is_mul ? BUSY : HOLD;
      BUSY: begin
        if (mul_busy && mul_done) begin
          state_d  = HOLD;
          load_mul = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (!in_valid) state_d = IDLE;
          else           state_d = is_mul ? BUSY : HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_alu) begin
        result_q    <= alu_res;
        result_hi_q <= '0;
        flags_q     <= alu_flags;
        err_q       <= alu_err;
      end else if (load_mul) begin
        result_q    <= mul_lo;
        result_hi_q <= mul_hi;
        flags_q     <= mul_flags;
        err_q       <= 1'b0;
      end
    end
  end

  assign out_valid = (state_q == HOLD);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flag_c    = flags_q.c;
  assign flag_v    = flags_q.v;
  assign flag_z    = flags_q.z;
  assign flag_n    = flags_q.n;
  assign err       = err_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// Bench for pipelined_alu at DATA_WIDTH=4: directed vector table, handshake
// corner sequences and a randomized run against an arithmetic reference model.
module tb_pipelined_alu;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         resetn;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b, result, result_hi;
  logic         flag_c, flag_v, flag_z, flag_n, err;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic c, v, z, n, e;
  } obs_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    obs_t         exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  pipelined_alu #(.DATA_WIDTH(W), .OP_WIDTH(3)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic obs_t sample();
    return {result, result_hi, flag_c, flag_v, flag_z, flag_n, err};
  endfunction

  function automatic obs_t mk(int res, int hi, bit c, bit v, bit z, bit n, bit e);
    obs_t o;
    o.res = W'(res);
    o.hi  = W'(hi);
    o.c = c; o.v = v; o.z = z; o.n = n; o.e = e;
    return o;
  endfunction

  // Reference: integer arithmetic on unsigned/signed interpretations of the operands.
  function automatic obs_t model(int opc, int ua, int ub);
    obs_t o;
    int m, sa, sb, s, r, p;
    m  = 1 << W;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    o  = '0;
    r  = 0;
    case (opc)
      0: begin r = ua + ub; o.c = (r >= m); s = sa + sb; o.v = (s >= m / 2) || (s < -m / 2); end
      1: begin r = ua - ub + m; o.c = (ua < ub); s = sa - sb; o.v = (s >= m / 2) || (s < -m / 2); end
      2: r = (m - 1) - ua;
      3: r = ua & ub;
      4: r = ua | ub;
      5: r = ua ^ ub;
      6: begin p = ua * ub; r = p; o.hi = W'(p / m); o.c = (p / m) != 0; end
      default: begin r = 0; o.e = 1'b1; end
    endcase
    o.res = W'(r % m);
    o.z   = (r % m) == 0;
    o.n   = (r % m) >= m / 2;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Called at a negedge. Issues one op, waits for its result, optionally stalls, consumes it.
  task automatic run_txn(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int stall, output obs_t got, output int lat, output int rdy_in_busy);
    int t;
    t = 0;
    rdy_in_busy = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op = 3'($urandom); a = W'($urandom); b = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (in_ready) rdy_in_busy++;
      @(negedge clk);
      lat++;
    end
    check("out_valid_wait", 32'(out_valid), 32'd1);
    got = sample();
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("hold_stable", 32'({out_valid, in_ready, sample()}), 32'({1'b1, 1'b0, got}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_dropped", 32'(out_valid), 32'd0);
  endtask

  initial begin
    obs_t got, exp;
    int   lat, rib, bad;

    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    vecs.push_back('{3'd0, 4'd12, 4'd12, mk( 8,  0, 1, 0, 0, 1, 0)});
    vecs.push_back('{3'd0, 4'd7,  4'd1,  mk( 8,  0, 0, 1, 0, 1, 0)});
    vecs.push_back('{3'd0, 4'd15, 4'd1,  mk( 0,  0, 1, 0, 1, 0, 0)});
    vecs.push_back('{3'd1, 4'd5,  4'd10, mk(11,  0, 1, 1, 0, 1, 0)});
    vecs.push_back('{3'd1, 4'd9,  4'd9,  mk( 0,  0, 0, 0, 1, 0, 0)});
    vecs.push_back('{3'd1, 4'd8,  4'd1,  mk( 7,  0, 0, 1, 0, 0, 0)});
    vecs.push_back('{3'd2, 4'd5,  4'd0,  mk(10,  0, 0, 0, 0, 1, 0)});
    vecs.push_back('{3'd3, 4'd12, 4'd10, mk( 8,  0, 0, 0, 0, 1, 0)});
    vecs.push_back('{3'd4, 4'd12, 4'd3,  mk(15,  0, 0, 0, 0, 1, 0)});
    vecs.push_back('{3'd5, 4'd12, 4'd10, mk( 6,  0, 0, 0, 0, 0, 0)});
    vecs.push_back('{3'd5, 4'd15, 4'd1,  mk(14,  0, 0, 0, 0, 1, 0)});
    vecs.push_back('{3'd6, 4'd11, 4'd9,  mk( 3,  6, 1, 0, 0, 0, 0)});
    vecs.push_back('{3'd6, 4'd0,  4'd15, mk( 0,  0, 0, 0, 1, 0, 0)});
    vecs.push_back('{3'd6, 4'd15, 4'd15, mk( 1, 14, 1, 0, 0, 0, 0)});
    vecs.push_back('{3'd7, 4'd3,  4'd4,  mk( 0,  0, 0, 0, 1, 0, 1)});

    #12;
    check("reset_outputs", 32'({out_valid, sample()}), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    foreach (vecs[i]) begin
      run_txn(vecs[i].op, vecs[i].a, vecs[i].b, i % 3, got, lat, rib);
      check($sformatf("vec%0d_out", i), 32'(got), 32'(vecs[i].exp));
      check($sformatf("vec%0d_lat", i), lat, (vecs[i].op == 3'd6) ? W : 0);
      check($sformatf("vec%0d_busy_rdy", i), rib, 0);
    end

    // Backpressure: AND held, an XOR presented meanwhile must wait.
    in_valid = 1'b1; op = 3'd3; a = 4'd12; b = 4'd10; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    op = 3'd5;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (!(out_valid && result == 4'd8 && !in_ready)) bad++;
      @(negedge clk);
    end
    check("bp_hold", bad, 0);
    out_ready = 1'b1;
    #1;
    check("bp_ready_passthru", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_xor", 32'({out_valid, result}), 32'({1'b1, 4'd6}));
    @(posedge clk);
    @(negedge clk);
    check("bp_idle", 32'(out_valid), 32'd0);

    // Back-to-back stream: NOT 15, OR 12|3, XOR 15^1.
    in_valid = 1'b1; op = 3'd2; a = 4'd15; b = 4'd0;
    @(posedge clk);
    @(negedge clk);
    check("b2b_not", 32'({out_valid, result, flag_z}), 32'({1'b1, 4'd0, 1'b1}));
    op = 3'd4; a = 4'd12; b = 4'd3;
    @(posedge clk);
    @(negedge clk);
    check("b2b_or", 32'({out_valid, result}), 32'({1'b1, 4'd15}));
    op = 3'd5; a = 4'd15; b = 4'd1;
    @(posedge clk);
    @(negedge clk);
    check("b2b_xor", 32'({out_valid, result}), 32'({1'b1, 4'd14}));
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("b2b_drain", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Reset in the middle of a MUL discards it.
    in_valid = 1'b1; op = 3'd6; a = 4'd11; b = 4'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_mid_mul", 32'({out_valid, sample()}), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    bad = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (out_valid || !in_ready) bad++;
    end
    check("rst_no_stale", bad, 0);
    run_txn(3'd7, 4'd9, 4'd2, 0, got, lat, rib);
    check("rsvd_after_rst", 32'(got), 32'(mk(0, 0, 0, 0, 1, 0, 1)));
    check("rsvd_lat", lat, 0);

    // Randomized ops with random consumer stalls.
    for (int i = 0; i < 150; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = W'($urandom);
      run_txn(ro, ra, rb, $urandom_range(0, 2), got, lat, rib);
      exp = model(int'(ro), int'(ra), int'(rb));
      check($sformatf("rand%0d_op%0d_%0d_%0d", i, ro, ra, rb), 32'(got), 32'(exp));
      check($sformatf("rand%0d_lat", i), lat, (ro == 3'd6) ? W : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
